// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   Request/response bundle for alu_exec_unit.
//   master : requester and response consumer (drives req_*, rsp_ready)
//   slave  : the execution unit (drives req_ready, rsp_*)
//   req_valid/req_ready      request handshake
//   req_sel                  0 = ALU op, 1 = shift op
//   req_src1/req_src2        operands; req_src1 is also the shift source
//   req_invertA/req_invertB  ALU operand inversion
//   req_operation            00 AND, 01 OR, 10 ADD, 11 SLT
//   req_leftRight            1 = left shift, 0 = right shift
//   req_shamt                shift amount
//   rsp_valid/rsp_ready      response handshake
//   rsp_result/rsp_zero/rsp_overflow  result and flags
interface alu_exec_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_sel;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_invertA;
  logic        req_invertB;
  logic [1:0]  req_operation;
  logic        req_leftRight;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;

  modport master (
    output req_valid, req_sel, req_src1, req_src2, req_invertA, req_invertB,
           req_operation, req_leftRight, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
  );

  modport slave (
    input  req_valid, req_sel, req_src1, req_src2, req_invertA, req_invertB,
           req_operation, req_leftRight, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Single-issue ALU / bit-serial shifter with valid/ready request and
//   response handshakes. ALU ops complete one edge after accept; shifts
//   take shamt+1 edges (one bit per edge).
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      alu_exec_unit_if.slave request/response bundle
//   op_count count of completed response handshakes (wraps)
module alu_exec_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_unit_if.slave   bus,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  logic [1:0]  state;
  logic [31:0] opa_q;      // src1 for ALU ops, working register for shifts
  logic [31:0] opb_q;
  logic        inv_a_q;
  logic        inv_b_q;
  logic [1:0]  op_q;
  logic        left_q;
  logic [4:0]  countdown;

  logic [31:0] a_p;
  logic [31:0] b_p;
  logic [31:0] sum;
  logic        ovf;
  logic [31:0] alu_res;
  logic        alu_ovf;

  always_comb begin
    a_p     = inv_a_q ? ~opa_q : opa_q;
    b_p     = inv_b_q ? ~opb_q : opb_q;
    // invertB doubles as the carry-in so that invertB+ADD is a subtract
    sum     = a_p + b_p + {31'b0, inv_b_q};
    ovf     = (a_p[31] == b_p[31]) && (sum[31] != a_p[31]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_p & b_p;
      OP_OR:  alu_res = a_p | b_p;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = ovf;
      end
      OP_SLT: alu_res = {31'b0, sum[31] ^ ovf};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_zero     <= 1'b0;
      bus.rsp_overflow <= 1'b0;
      op_count         <= '0;
      countdown        <= '0;
      opa_q            <= '0;
      opb_q            <= '0;
      inv_a_q          <= 1'b0;
      inv_b_q          <= 1'b0;
      op_q             <= OP_AND;
      left_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            opa_q         <= bus.req_src1;
            opb_q         <= bus.req_src2;
            inv_a_q       <= bus.req_invertA;
            inv_b_q       <= bus.req_invertB;
            op_q          <= bus.req_operation;
            left_q        <= bus.req_leftRight;
            bus.req_ready <= 1'b0;
            if (bus.req_sel) begin
              countdown <= bus.req_shamt;
              state     <= SHIFT;
            end else begin
              countdown <= '0;
              state     <= EXEC;
            end
          end else begin
            // first edge out of reset lands here and raises req_ready
            bus.req_ready <= 1'b1;
          end
        end
        EXEC: begin
          bus.rsp_result   <= alu_res;
          bus.rsp_zero     <= (alu_res == '0);
          bus.rsp_overflow <= alu_ovf;
          bus.rsp_valid    <= 1'b1;
          state            <= RESP;
        end
        SHIFT: begin
          if (countdown != '0) begin
            opa_q     <= left_q ? {opa_q[30:0], 1'b0} : {1'b0, opa_q[31:1]};
            countdown <= countdown - 5'd1;
          end else begin
            bus.rsp_result   <= opa_q;
            bus.rsp_zero     <= (opa_q == '0);
            bus.rsp_overflow <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            op_count      <= op_count + CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
